// File: rtl/ccx_spc_rpt_if.sv
// Core/crossbar-side bundle for the CCX/SPC repeater pipe: raw inputs plus their delayed copies.
// master drives the raw signals and observes the _buf copies; slave is the repeater itself.
interface ccx_spc_rpt_if #(
   parameter int PCX_W = 124,
   parameter int CPX_W = 145
);
   logic [4:0]       spc_pcx_req_pq;
   logic             spc_pcx_atom_pq;
   logic [PCX_W-1:0] spc_pcx_data_pa;
   logic [4:0]       pcx_spc_grant_px;
   logic [CPX_W-1:0] cpx_spc_data_cx2;
   logic             cpx_spc_data_rdy_cx2;

   logic [4:0]       spc_pcx_req_pq_buf;
   logic             spc_pcx_atom_pq_buf;
   logic [PCX_W-1:0] spc_pcx_data_pa_buf;
   logic [4:0]       pcx_spc_grant_px_buf;
   logic [CPX_W-1:0] cpx_spc_data_cx2_buf;
   logic             cpx_spc_data_rdy_cx2_buf;

   modport master (
      output spc_pcx_req_pq, spc_pcx_atom_pq, spc_pcx_data_pa,
             pcx_spc_grant_px, cpx_spc_data_cx2, cpx_spc_data_rdy_cx2,
      input  spc_pcx_req_pq_buf, spc_pcx_atom_pq_buf, spc_pcx_data_pa_buf,
             pcx_spc_grant_px_buf, cpx_spc_data_cx2_buf, cpx_spc_data_rdy_cx2_buf
   );

   modport slave (
      input  spc_pcx_req_pq, spc_pcx_atom_pq, spc_pcx_data_pa,
             pcx_spc_grant_px, cpx_spc_data_cx2, cpx_spc_data_rdy_cx2,
      output spc_pcx_req_pq_buf, spc_pcx_atom_pq_buf, spc_pcx_data_pa_buf,
             pcx_spc_grant_px_buf, cpx_spc_data_cx2_buf, cpx_spc_data_rdy_cx2_buf
   );
endinterface

// File: rtl/ccx_spc_rpt_pipe.sv
// STAGES-deep repeater between core and crossbar with a per-destination outstanding-request monitor.
// Optional CPX parity carry/check is enabled with macro CCX_RPT_PARITY_EN.
module ccx_spc_rpt_pipe #(
   parameter int PCX_W  = 124,
   parameter int CPX_W  = 145,
   parameter int STAGES = 2
) (
   input  logic           rclk,
   input  logic           arst,
   ccx_spc_rpt_if.slave   bus,
   output logic [4:0]     pcx_ovfl_err,
   output logic [4:0]     pcx_unfl_err,
   output logic           pcx_outst_any,
   output logic           cpx_par_err
);

   logic [4:0]       req_pipe_r      [STAGES];
   logic             atom_pipe_r     [STAGES];
   logic [PCX_W-1:0] pcx_data_pipe_r [STAGES];
   logic [4:0]       grant_pipe_r    [STAGES];
   logic [CPX_W-1:0] cpx_data_pipe_r [STAGES];
   logic             rdy_pipe_r      [STAGES];

   logic [1:0] cnt_r      [5];
   logic [1:0] cnt_nxt_s  [5];
   logic [4:0] ovfl_set_s;
   logic [4:0] unfl_set_s;
   logic [4:0] cnt_nz_s;
   logic [4:0] ovfl_r;
   logic [4:0] unfl_r;
   logic       outst_any_r;

   // Unconditional delay line; every field shifts in lock-step so offsets are preserved.
   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < STAGES; i++) begin
            req_pipe_r[i]      <= 5'b0_0000;
            atom_pipe_r[i]     <= 1'b0;
            pcx_data_pipe_r[i] <= {PCX_W{1'b0}};
            grant_pipe_r[i]    <= 5'b0_0000;
            cpx_data_pipe_r[i] <= {CPX_W{1'b0}};
            rdy_pipe_r[i]      <= 1'b0;
         end
      end else begin
         req_pipe_r[0]      <= bus.spc_pcx_req_pq;
         atom_pipe_r[0]     <= bus.spc_pcx_atom_pq;
         pcx_data_pipe_r[0] <= bus.spc_pcx_data_pa;
         grant_pipe_r[0]    <= bus.pcx_spc_grant_px;
         cpx_data_pipe_r[0] <= bus.cpx_spc_data_cx2;
         rdy_pipe_r[0]      <= bus.cpx_spc_data_rdy_cx2;
         for (int i = 1; i < STAGES; i++) begin
            req_pipe_r[i]      <= req_pipe_r[i-1];
            atom_pipe_r[i]     <= atom_pipe_r[i-1];
            pcx_data_pipe_r[i] <= pcx_data_pipe_r[i-1];
            grant_pipe_r[i]    <= grant_pipe_r[i-1];
            cpx_data_pipe_r[i] <= cpx_data_pipe_r[i-1];
            rdy_pipe_r[i]      <= rdy_pipe_r[i-1];
         end
      end
   end

   assign bus.spc_pcx_req_pq_buf       = req_pipe_r[STAGES-1];
   assign bus.spc_pcx_atom_pq_buf      = atom_pipe_r[STAGES-1];
   assign bus.spc_pcx_data_pa_buf      = pcx_data_pipe_r[STAGES-1];
   assign bus.pcx_spc_grant_px_buf     = grant_pipe_r[STAGES-1];
   assign bus.cpx_spc_data_cx2_buf     = cpx_data_pipe_r[STAGES-1];
   assign bus.cpx_spc_data_rdy_cx2_buf = rdy_pipe_r[STAGES-1];

   // Outstanding-count next state; saturates at 2 and 0 and flags the offending edge.
   always_comb begin
      for (int d = 0; d < 5; d++) begin
         cnt_nxt_s[d]  = cnt_r[d];
         ovfl_set_s[d] = 1'b0;
         unfl_set_s[d] = 1'b0;
         cnt_nz_s[d]   = (cnt_r[d] != 2'd0);
         case ({bus.spc_pcx_req_pq[d], bus.pcx_spc_grant_px[d]})
            2'b10: begin
               if (cnt_r[d] == 2'd2) begin
                  ovfl_set_s[d] = 1'b1;
               end else begin
                  cnt_nxt_s[d] = cnt_r[d] + 2'd1;
               end
            end
            2'b01: begin
               if (cnt_r[d] == 2'd0) begin
                  unfl_set_s[d] = 1'b1;
               end else begin
                  cnt_nxt_s[d] = cnt_r[d] - 2'd1;
               end
            end
            default: cnt_nxt_s[d] = cnt_r[d];
         endcase
      end
   end

   // Counters, sticky error bits and the registered any-outstanding summary.
   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         for (int d = 0; d < 5; d++) begin
            cnt_r[d] <= 2'd0;
         end
         ovfl_r      <= 5'b0_0000;
         unfl_r      <= 5'b0_0000;
         outst_any_r <= 1'b0;
      end else begin
         for (int d = 0; d < 5; d++) begin
            cnt_r[d] <= cnt_nxt_s[d];
         end
         ovfl_r      <= ovfl_r | ovfl_set_s;
         unfl_r      <= unfl_r | unfl_set_s;
         outst_any_r <= |cnt_nz_s;
      end
   end

   assign pcx_ovfl_err  = ovfl_r;
   assign pcx_unfl_err  = unfl_r;
   assign pcx_outst_any = outst_any_r;

`ifdef CCX_RPT_PARITY_EN
   function automatic logic even_par(input logic [CPX_W-1:0] v);
      return ^v;
   endfunction

   logic par_pipe_r [STAGES];
   logic par_err_r;
   logic par_mis_s;

   assign par_mis_s = rdy_pipe_r[STAGES-1] &
                      (even_par(cpx_data_pipe_r[STAGES-1]) != par_pipe_r[STAGES-1]);

   // Parity generated at entry rides with the packet and is checked at exit.
   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < STAGES; i++) begin
            par_pipe_r[i] <= 1'b0;
         end
         par_err_r <= 1'b0;
      end else begin
         par_pipe_r[0] <= even_par(bus.cpx_spc_data_cx2);
         for (int i = 1; i < STAGES; i++) begin
            par_pipe_r[i] <= par_pipe_r[i-1];
         end
         par_err_r <= par_err_r | par_mis_s;
      end
   end

   assign cpx_par_err = par_err_r;
`else
   assign cpx_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ccx_spc_rpt_pipe.sv
// Directed bench for ccx_spc_rpt_pipe (STAGES=2); parity scenario only built with CCX_RPT_PARITY_EN.
module tb_ccx_spc_rpt_pipe;
   localparam int PCX_W = 124;
   localparam int CPX_W = 145;

   logic       rclk;
   logic       arst;
   logic [4:0] pcx_ovfl_err;
   logic [4:0] pcx_unfl_err;
   logic       pcx_outst_any;
   logic       cpx_par_err;
   int         checks;
   int         failures;

   ccx_spc_rpt_if #(.PCX_W(PCX_W), .CPX_W(CPX_W)) bus ();

   ccx_spc_rpt_pipe #(.PCX_W(PCX_W), .CPX_W(CPX_W), .STAGES(2)) dut (
      .rclk          (rclk),
      .arst          (arst),
      .bus           (bus),
      .pcx_ovfl_err  (pcx_ovfl_err),
      .pcx_unfl_err  (pcx_unfl_err),
      .pcx_outst_any (pcx_outst_any),
      .cpx_par_err   (cpx_par_err)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic step();
      @(posedge rclk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.spc_pcx_req_pq       = 5'b0_0000;
      bus.spc_pcx_atom_pq      = 1'b0;
      bus.spc_pcx_data_pa      = {PCX_W{1'b0}};
      bus.pcx_spc_grant_px     = 5'b0_0000;
      bus.cpx_spc_data_cx2     = {CPX_W{1'b0}};
      bus.cpx_spc_data_rdy_cx2 = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      @(negedge rclk);
      arst = 1'b1;
      @(negedge rclk);
      arst = 1'b0;
   endtask

   task automatic test_reset();
      bus.spc_pcx_req_pq       = 5'b1_1111;
      bus.spc_pcx_atom_pq      = 1'b1;
      bus.spc_pcx_data_pa      = {PCX_W{1'b1}};
      bus.pcx_spc_grant_px     = 5'b1_1111;
      bus.cpx_spc_data_cx2     = {CPX_W{1'b1}};
      bus.cpx_spc_data_rdy_cx2 = 1'b1;
      arst = 1'b1;
      step();
      step();
      checks++;
      if (bus.spc_pcx_req_pq_buf !== 5'b0_0000 || bus.spc_pcx_atom_pq_buf !== 1'b0 ||
          bus.spc_pcx_data_pa_buf !== {PCX_W{1'b0}} || bus.pcx_spc_grant_px_buf !== 5'b0_0000 ||
          bus.cpx_spc_data_cx2_buf !== {CPX_W{1'b0}} || bus.cpx_spc_data_rdy_cx2_buf !== 1'b0) begin
         failures++;
         $display("FAIL reset_bufs: req=%b rdy=%b expected all zero", bus.spc_pcx_req_pq_buf,
                  bus.cpx_spc_data_rdy_cx2_buf);
      end
      checks++;
      if (pcx_ovfl_err !== 5'b0_0000 || pcx_unfl_err !== 5'b0_0000 ||
          pcx_outst_any !== 1'b0 || cpx_par_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_status: ovfl=%b unfl=%b any=%b par=%b expected 0", pcx_ovfl_err,
                  pcx_unfl_err, pcx_outst_any, cpx_par_err);
      end
      // first edge after release captures normally
      clear_inputs();
      bus.spc_pcx_req_pq = 5'b1_0000;
      @(negedge rclk);
      arst = 1'b0;
      step();
      bus.spc_pcx_req_pq = 5'b0_0000;
      step();
      checks++;
      if (bus.spc_pcx_req_pq_buf !== 5'b1_0000) begin
         failures++;
         $display("FAIL reset_first_edge: got %b expected %b", bus.spc_pcx_req_pq_buf, 5'b1_0000);
      end
   endtask

   task automatic test_latency();
      logic [PCX_W-1:0] pdat;
      logic [CPX_W-1:0] cdat;
      pdat = {{15{8'hA5}}, 4'hA};
      cdat = {{18{8'h3C}}, 1'b1};
      do_reset();
      bus.spc_pcx_req_pq       = 5'b0_0100;
      bus.spc_pcx_atom_pq      = 1'b1;
      bus.pcx_spc_grant_px     = 5'b0_0010;
      bus.cpx_spc_data_cx2     = cdat;
      bus.cpx_spc_data_rdy_cx2 = 1'b1;
      step();
      clear_inputs();
      bus.spc_pcx_data_pa = pdat;
      checks++;
      if (bus.spc_pcx_req_pq_buf !== 5'b0_0000) begin
         failures++;
         $display("FAIL lat_req_early: got %b expected %b", bus.spc_pcx_req_pq_buf, 5'b0_0000);
      end
      step();
      bus.spc_pcx_data_pa = {PCX_W{1'b0}};
      checks++;
      if (bus.spc_pcx_req_pq_buf !== 5'b0_0100 || bus.spc_pcx_atom_pq_buf !== 1'b1) begin
         failures++;
         $display("FAIL lat_req: req=%b atom=%b expected 00100 1", bus.spc_pcx_req_pq_buf,
                  bus.spc_pcx_atom_pq_buf);
      end
      checks++;
      if (bus.pcx_spc_grant_px_buf !== 5'b0_0010 || bus.cpx_spc_data_rdy_cx2_buf !== 1'b1 ||
          bus.cpx_spc_data_cx2_buf !== cdat) begin
         failures++;
         $display("FAIL lat_grant_cpx: grant=%b rdy=%b cpx=%h expected 00010 1 %h",
                  bus.pcx_spc_grant_px_buf, bus.cpx_spc_data_rdy_cx2_buf,
                  bus.cpx_spc_data_cx2_buf, cdat);
      end
      checks++;
      if (bus.spc_pcx_data_pa_buf !== {PCX_W{1'b0}}) begin
         failures++;
         $display("FAIL lat_data_early: got %h expected 0", bus.spc_pcx_data_pa_buf);
      end
      step();
      checks++;
      if (bus.spc_pcx_data_pa_buf !== pdat || bus.spc_pcx_req_pq_buf !== 5'b0_0000 ||
          bus.cpx_spc_data_rdy_cx2_buf !== 1'b0) begin
         failures++;
         $display("FAIL lat_data: data=%h req=%b rdy=%b expected %h 00000 0",
                  bus.spc_pcx_data_pa_buf, bus.spc_pcx_req_pq_buf,
                  bus.cpx_spc_data_rdy_cx2_buf, pdat);
      end
   endtask

   task automatic test_ovfl();
      do_reset();
      bus.spc_pcx_req_pq = 5'b0_0001;
      step();
      step();
      checks++;
      if (pcx_ovfl_err !== 5'b0_0000 || pcx_outst_any !== 1'b1) begin
         failures++;
         $display("FAIL ovfl_at_two: ovfl=%b any=%b expected 00000 1", pcx_ovfl_err, pcx_outst_any);
      end
      step();
      bus.spc_pcx_req_pq = 5'b0_0000;
      checks++;
      if (pcx_ovfl_err !== 5'b0_0001 || bus.spc_pcx_req_pq_buf !== 5'b0_0001) begin
         failures++;
         $display("FAIL ovfl_set: ovfl=%b req_buf=%b expected 00001 00001", pcx_ovfl_err,
                  bus.spc_pcx_req_pq_buf);
      end
      step();
      checks++;
      if (bus.spc_pcx_req_pq_buf !== 5'b0_0001) begin
         failures++;
         $display("FAIL ovfl_forward: got %b expected 00001", bus.spc_pcx_req_pq_buf);
      end
      // two grants drain the count back to zero
      bus.pcx_spc_grant_px = 5'b0_0001;
      step();
      step();
      bus.pcx_spc_grant_px = 5'b0_0000;
      checks++;
      if (pcx_outst_any !== 1'b1 || pcx_unfl_err !== 5'b0_0000) begin
         failures++;
         $display("FAIL drain_lag: any=%b unfl=%b expected 1 00000", pcx_outst_any, pcx_unfl_err);
      end
      step();
      checks++;
      if (pcx_outst_any !== 1'b0 || pcx_ovfl_err !== 5'b0_0001) begin
         failures++;
         $display("FAIL drain_done: any=%b ovfl=%b expected 0 00001", pcx_outst_any, pcx_ovfl_err);
      end
   endtask

   task automatic test_unfl();
      do_reset();
      bus.pcx_spc_grant_px = 5'b0_1000;
      step();
      bus.pcx_spc_grant_px = 5'b0_0000;
      checks++;
      if (pcx_unfl_err !== 5'b0_1000) begin
         failures++;
         $display("FAIL unfl_set: got %b expected 01000", pcx_unfl_err);
      end
      bus.spc_pcx_req_pq = 5'b0_0010;
      step();
      bus.pcx_spc_grant_px = 5'b0_0110;
      bus.spc_pcx_req_pq   = 5'b0_0110;
      step();
      bus.spc_pcx_req_pq   = 5'b0_0000;
      bus.pcx_spc_grant_px = 5'b0_0010;
      step();
      bus.pcx_spc_grant_px = 5'b0_0000;
      checks++;
      if (pcx_unfl_err !== 5'b0_1000 || pcx_ovfl_err !== 5'b0_0000 || pcx_outst_any !== 1'b1) begin
         failures++;
         $display("FAIL req_grant_same: unfl=%b ovfl=%b any=%b expected 01000 00000 1",
                  pcx_unfl_err, pcx_ovfl_err, pcx_outst_any);
      end
      step();
      checks++;
      if (pcx_outst_any !== 1'b0 || pcx_unfl_err !== 5'b0_1000) begin
         failures++;
         $display("FAIL unfl_drain: any=%b unfl=%b expected 0 01000", pcx_outst_any, pcx_unfl_err);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      bus.spc_pcx_req_pq       = 5'b0_0001;
      bus.cpx_spc_data_cx2     = {{18{8'h5A}}, 1'b1};
      bus.cpx_spc_data_rdy_cx2 = 1'b1;
      step();
      step();
      checks++;
      if (bus.cpx_spc_data_rdy_cx2_buf !== 1'b1 || pcx_outst_any !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: rdy_buf=%b any=%b expected 1 1", bus.cpx_spc_data_rdy_cx2_buf,
                  pcx_outst_any);
      end
      #2;
      arst = 1'b1;
      #1;
      checks++;
      if (bus.cpx_spc_data_rdy_cx2_buf !== 1'b0 || bus.spc_pcx_req_pq_buf !== 5'b0_0000 ||
          bus.cpx_spc_data_cx2_buf !== {CPX_W{1'b0}} || pcx_outst_any !== 1'b0) begin
         failures++;
         $display("FAIL mid_async_clear: rdy_buf=%b req_buf=%b any=%b expected 0",
                  bus.cpx_spc_data_rdy_cx2_buf, bus.spc_pcx_req_pq_buf, pcx_outst_any);
      end
      clear_inputs();
      @(negedge rclk);
      arst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (bus.cpx_spc_data_rdy_cx2_buf !== 1'b0 || bus.spc_pcx_req_pq_buf !== 5'b0_0000) begin
            failures++;
            $display("FAIL mid_no_pulse[%0d]: rdy_buf=%b req_buf=%b expected 0 00000", k,
                     bus.cpx_spc_data_rdy_cx2_buf, bus.spc_pcx_req_pq_buf);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [CPX_W-1:0] vals [6];
      logic             rdys [6];
      for (int k = 0; k < 6; k++) begin
         vals[k] = {{17{8'(8'h11 * (k + 1))}}, 9'(9'h0F3 + k)};
         rdys[k] = k[0];
      end
      do_reset();
      for (int k = 0; k < 7; k++) begin
         if (k < 6) begin
            bus.cpx_spc_data_cx2     = vals[k];
            bus.cpx_spc_data_rdy_cx2 = rdys[k];
         end else begin
            clear_inputs();
         end
         step();
         if (k >= 1) begin
            checks++;
            if (bus.cpx_spc_data_cx2_buf !== vals[k-1] ||
                bus.cpx_spc_data_rdy_cx2_buf !== rdys[k-1]) begin
               failures++;
               $display("FAIL b2b[%0d]: cpx=%h rdy=%b expected %h %b", k - 1,
                        bus.cpx_spc_data_cx2_buf, bus.cpx_spc_data_rdy_cx2_buf,
                        vals[k-1], rdys[k-1]);
            end
         end
      end
      checks++;
      if (cpx_par_err !== 1'b0) begin
         failures++;
         $display("FAIL b2b_no_par: got %b expected 0", cpx_par_err);
      end
   endtask

`ifdef CCX_RPT_PARITY_EN
   task automatic test_parity();
      do_reset();
      bus.cpx_spc_data_cx2     = {{18{8'hC3}}, 1'b0};
      bus.cpx_spc_data_rdy_cx2 = 1'b1;
      step();
      clear_inputs();
      dut.cpx_data_pipe_r[0][0] = ~dut.cpx_data_pipe_r[0][0];
      step();
      checks++;
      if (cpx_par_err !== 1'b0) begin
         failures++;
         $display("FAIL par_early: got %b expected 0", cpx_par_err);
      end
      step();
      checks++;
      if (cpx_par_err !== 1'b1) begin
         failures++;
         $display("FAIL par_set: got %b expected 1", cpx_par_err);
      end
      step();
      step();
      checks++;
      if (cpx_par_err !== 1'b1) begin
         failures++;
         $display("FAIL par_sticky: got %b expected 1", cpx_par_err);
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      arst     = 1'b1;
      clear_inputs();
      test_reset();
      test_latency();
      test_ovfl();
      test_unfl();
      test_reset_midstream();
      test_back_to_back();
`ifdef CCX_RPT_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
